// File: rtl/alarm_controller.sv
// alarm_controller: intruder-alarm FSM with exit/entry delays, siren timeout, key-error lockout.
// Ports: clk, reset (sync, active-high); key_pulse/sensor (async, synchronized inside);
//        key_status (0=OK, 2=ERROR, 3=NOKEY, 1=reserved); armed/siren/lockout/state_dbg/fail_cnt (registered).
module alarm_controller #(
  parameter logic [31:0] EXIT_CYC  = 32'd50_000_000,
  parameter logic [31:0] ENTRY_CYC = 32'd25_000_000,
  parameter logic [31:0] SIREN_CYC = 32'd500_000_000,
  parameter logic [31:0] LOCK_CYC  = 32'd250_000_000,
  parameter int          MAX_FAILS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_pulse,
  input  logic [1:0] key_status,
  input  logic       sensor,
  output logic       armed,
  output logic       siren,
  output logic       lockout,
  output logic [3:0] fail_cnt,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    S_DIS   = 3'd0,
    S_EXIT  = 3'd1,
    S_ARM   = 3'd2,
    S_ENTRY = 3'd3,
    S_ALARM = 3'd4,
    S_LOCK  = 3'd5
  } state_t;
  localparam logic [3:0] MF = 4'(MAX_FAILS);
  state_t      r_state, w_next;
  logic [31:0] r_cnt, w_cnt, w_load;
  logic [3:0]  r_fail, w_fail, w_inc;
  logic        r_key_s1, r_key_s2, r_key_prev, r_key_arm, r_live;
  logic        r_sen_s1, r_sen_s2;
  logic        r_armed, r_siren, r_lockout;
  logic        w_ev, w_kok, w_kerr, w_esc, w_exp;
  // r_key_arm only sets once a low key_pulse has been synchronized after reset,
  // so a key held high through reset release cannot produce an event.
  assign w_ev   = r_key_s2 & ~r_key_prev & r_key_arm;
  assign w_kok  = w_ev & (key_status == 2'd0);
  assign w_kerr = w_ev & (key_status == 2'd2);
  assign w_inc  = (r_fail >= MF) ? MF : r_fail + 4'd1;
  assign w_esc  = w_kerr & (w_inc == MF);
  assign w_exp  = (r_cnt == 32'd0) & (r_state inside {S_EXIT, S_ENTRY, S_ALARM, S_LOCK});
  always_comb begin
    w_next = r_state;
    w_fail = w_kerr ? w_inc : r_fail;
    if (r_state == S_LOCK) begin
      w_fail = r_fail;
      if (w_exp) begin
        w_next = S_DIS;
        w_fail = 4'd0;
      end
    end else if (w_kok) begin
      w_next = (r_state == S_DIS) ? S_EXIT : S_DIS;
      w_fail = 4'd0;
    end else begin
      case (r_state)
        S_DIS: if (w_esc) begin
          w_next = S_LOCK;
          w_fail = 4'd0;
        end
        S_EXIT:  if (w_exp) w_next = S_ARM;
        S_ARM: if (w_esc) begin
          w_next = S_ALARM;
          w_fail = 4'd0;
        end else if (r_sen_s2) w_next = S_ENTRY;
        S_ENTRY: if (w_esc | w_exp) begin
          w_next = S_ALARM;
          w_fail = 4'd0;
        end
        S_ALARM: if (w_exp) w_next = S_ARM;
        default: w_next = r_state;
      endcase
    end
  end
  assign w_load = (w_next == S_EXIT)  ? EXIT_CYC - 32'd1 :
                  (w_next == S_ENTRY) ? ENTRY_CYC - 32'd1 :
                  (w_next == S_ALARM) ? SIREN_CYC - 32'd1 :
                  (w_next == S_LOCK)  ? LOCK_CYC - 32'd1 : 32'd0;
  assign w_cnt  = (w_next != r_state) ? w_load : (r_cnt != 32'd0) ? r_cnt - 32'd1 : 32'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_DIS;
      r_cnt      <= 32'd0;
      r_fail     <= 4'd0;
      r_key_s1   <= 1'b0;
      r_key_s2   <= 1'b0;
      r_key_prev <= 1'b0;
      r_key_arm  <= 1'b0;
      r_live     <= 1'b0;
      r_sen_s1   <= 1'b0;
      r_sen_s2   <= 1'b0;
      r_armed    <= 1'b0;
      r_siren    <= 1'b0;
      r_lockout  <= 1'b0;
    end else begin
      r_key_s1   <= key_pulse;
      r_key_s2   <= r_key_s1;
      r_key_prev <= r_key_s2;
      r_live     <= 1'b1;
      r_key_arm  <= r_key_arm | (r_live & ~r_key_s1);
      r_sen_s1   <= sensor;
      r_sen_s2   <= r_sen_s1;
      r_state    <= w_next;
      r_cnt      <= w_cnt;
      r_fail     <= w_fail;
      r_armed    <= w_next inside {S_ARM, S_ENTRY, S_ALARM};
      r_siren    <= w_next == S_ALARM;
      r_lockout  <= w_next == S_LOCK;
    end
  end
  assign armed     = r_armed;
  assign siren     = r_siren;
  assign lockout   = r_lockout;
  assign fail_cnt  = r_fail;
  assign state_dbg = r_state;
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed + random check of alarm_controller against a cycle-level reference model.
module tb_alarm_controller;
  localparam int EX = 10, EN = 8, SI = 20, LK = 15, MF = 3;
  logic       clk = 1'b0, reset = 1'b1, key_pulse = 1'b0, sensor = 1'b0;
  logic [1:0] key_status = 2'd0;
  logic       armed, siren, lockout;
  logic [3:0] fail_cnt;
  logic [2:0] state_dbg;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  alarm_controller #(
    .EXIT_CYC(32'd10), .ENTRY_CYC(32'd8), .SIREN_CYC(32'd20), .LOCK_CYC(32'd15), .MAX_FAILS(3)
  ) dut (
    .clk(clk), .reset(reset), .key_pulse(key_pulse), .key_status(key_status), .sensor(sensor),
    .armed(armed), .siren(siren), .lockout(lockout), .fail_cnt(fail_cnt), .state_dbg(state_dbg)
  );
  // Reference model: state, elapsed cycles in state, and raw input history per edge.
  // kh[i] is key_pulse sampled i+1 edges ago; 2 marks a pre-reset (unusable) sample.
  int m_st = 0, m_fail = 0, m_el = 0;
  int kh[3] = '{2, 2, 2};
  int sh[2] = '{0, 0};
  always @(posedge clk) begin
    int ns, nf, dur, inc;
    bit ev, kok, kerr, esc, ex, sen;
    if (reset) begin
      m_st = 0; m_fail = 0; m_el = 0;
      kh = '{2, 2, 2};
      sh = '{0, 0};
    end else begin
      ev   = (kh[1] == 1) && (kh[2] == 0);
      sen  = sh[1] == 1;
      kok  = ev && key_status == 2'd0;
      kerr = ev && key_status == 2'd2;
      dur  = m_st == 1 ? EX : m_st == 3 ? EN : m_st == 4 ? SI : m_st == 5 ? LK : 0;
      ex   = dur != 0 && m_el == dur - 1;
      inc  = m_fail + 1 > MF ? MF : m_fail + 1;
      esc  = kerr && inc == MF;
      ns   = m_st;
      nf   = kerr ? inc : m_fail;
      if (m_st == 5) begin
        nf = 0;
        if (ex) ns = 0;
      end else if (kok) begin
        ns = m_st == 0 ? 1 : 0;
        nf = 0;
      end else if (esc && m_st != 1 && m_st != 4) begin
        ns = m_st == 0 ? 5 : 4;
        nf = 0;
      end else if (ex) begin
        ns = m_st == 3 ? 4 : 2;
        if (ns == 4) nf = 0;
      end else if (sen && m_st == 2) ns = 3;
      m_el = ns == m_st ? m_el + 1 : 0;
      m_st = ns;
      m_fail = nf;
      kh[2] = kh[1]; kh[1] = kh[0]; kh[0] = int'(key_pulse);
      sh[1] = sh[0]; sh[0] = int'(sensor);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic tick(input logic kp, input logic [1:0] ks, input logic sn);
    key_pulse = kp; key_status = ks; sensor = sn;
    @(posedge clk);
    #1;
    chk("model_state", 32'(state_dbg), 32'(m_st));
    chk("model_armed", 32'(armed), 32'(m_st inside {2, 3, 4}));
    chk("model_siren", 32'(siren), 32'(m_st == 4));
    chk("model_lockout", 32'(lockout), 32'(m_st == 5));
    chk("model_fail", 32'(fail_cnt), 32'(m_fail));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 1'b0);
  endtask
  task automatic pulse(input logic [1:0] ks);
    tick(1'b1, ks, 1'b0);
    tick(1'b0, ks, 1'b0);
    tick(1'b0, ks, 1'b0);
  endtask
  initial begin
    logic kp;
    idle(2);
    chk("reset_state", 32'(state_dbg), 0);
    chk("reset_outputs", 32'({armed, siren, lockout, fail_cnt}), 0);
    reset = 1'b0;
    idle(2);
    // Arm: KOK -> EXIT three edges later, ARMED exactly 10 cycles after that
    pulse(2'd0);
    chk("arm_exit", 32'(state_dbg), 1);
    idle(9);
    chk("exit_hold", 32'(state_dbg), 1);
    idle(1);
    chk("armed_state", 32'(state_dbg), 2);
    chk("armed_out", 32'(armed), 1);
    // Sensor trip -> ENTRY, expiry -> ALARM for 20 cycles -> re-armed
    tick(1'b0, 2'd0, 1'b1);
    idle(2);
    chk("entry_state", 32'(state_dbg), 3);
    idle(7);
    chk("entry_hold", 32'(state_dbg), 3);
    idle(1);
    chk("alarm_state", 32'(state_dbg), 4);
    chk("alarm_siren", 32'(siren), 1);
    idle(19);
    chk("siren_hold", 32'(siren), 1);
    idle(1);
    chk("rearm_state", 32'(state_dbg), 2);
    chk("rearm_siren", 32'(siren), 0);
    // KOK and sensor detected together: KOK wins
    tick(1'b1, 2'd0, 1'b1);
    idle(2);
    chk("kok_beats_sensor", 32'(state_dbg), 0);
    pulse(2'd2);
    chk("kerr_fail1", 32'(fail_cnt), 1);
    pulse(2'd2);
    chk("kerr_fail2", 32'(fail_cnt), 2);
    pulse(2'd0);
    chk("kok_clears_fail", 32'(fail_cnt), 0);
    chk("kok_to_exit", 32'(state_dbg), 1);
    pulse(2'd0);
    chk("kok_disarm", 32'(state_dbg), 0);
    // Status 3 and 1 ignored
    pulse(2'd3);
    pulse(2'd1);
    chk("nokey_ignored", 32'({state_dbg, fail_cnt}), 0);
    // Three KERR in DISARMED -> LOCKOUT; KOK ignored; 15 cycles later DISARMED
    pulse(2'd2);
    pulse(2'd2);
    chk("lock_pre_fail", 32'(fail_cnt), 2);
    pulse(2'd2);
    chk("lock_state", 32'(state_dbg), 5);
    chk("lock_out", 32'(lockout), 1);
    chk("lock_fail", 32'(fail_cnt), 0);
    pulse(2'd0);
    chk("lock_kok_ignored", 32'(state_dbg), 5);
    idle(11);
    chk("lock_hold", 32'(state_dbg), 5);
    idle(1);
    chk("lock_release", 32'(state_dbg), 0);
    // KOK landing exactly on ENTRY expiry
    pulse(2'd0);
    idle(10);
    tick(1'b0, 2'd0, 1'b1);
    idle(2);
    chk("entry2_state", 32'(state_dbg), 3);
    idle(5);
    tick(1'b1, 2'd0, 1'b0);
    tick(1'b0, 2'd0, 1'b0);
    chk("entry2_hold", 32'(state_dbg), 3);
    tick(1'b0, 2'd0, 1'b0);
    chk("kok_on_expiry", 32'(state_dbg), 0);
    chk("kok_on_expiry_siren", 32'(siren), 0);
    // Reset mid-ALARM with key held high across reset
    pulse(2'd0);
    idle(10);
    tick(1'b0, 2'd0, 1'b1);
    idle(10);
    chk("alarm2_state", 32'(state_dbg), 4);
    idle(5);
    reset = 1'b1;
    tick(1'b1, 2'd0, 1'b0);
    chk("reset_mid_alarm", 32'({armed, siren, lockout, fail_cnt, state_dbg}), 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1, 2'd0, 1'b0);
    chk("held_key_no_event", 32'(state_dbg), 0);
    idle(2);
    pulse(2'd0);
    chk("key_after_release", 32'(state_dbg), 1);
    // Random traffic with occasional resets, two toggle densities
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 249) == 0;
      kp = key_pulse;
      if ($urandom_range(0, i < 1500 ? 3 : 19) == 0) kp = ~kp;
      tick(kp, 2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter EXIT_CYC, default 50_000_000: clk cycles spent in EXIT_DELAY; legal range 1..2^32-1.
REQ-002 Parameter ENTRY_CYC, default 25_000_000: clk cycles spent in ENTRY_DELAY; legal range 1..2^32-1.
REQ-003 Parameter SIREN_CYC, default 500_000_000: clk cycles spent in ALARM before auto re-arm; legal range 1..2^32-1.
REQ-004 Parameter LOCK_CYC, default 250_000_000: clk cycles spent in LOCKOUT; legal range 1..2^32-1.
REQ-005 Parameter MAX_FAILS, default 3: consecutive key errors that trigger escalation; legal range 1..15.
REQ-006 clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 key_pulse  input  1  asynchronous "4th/any key entered" strobe, the same signal that clocks the key checker.
REQ-009 key_status  input  2  checker verdict: 0=OK, 2=ERROR, 3=NOKEY, 1=reserved.
REQ-010 sensor  input  1  asynchronous door/motion sensor, active-high.
REQ-011 armed  output  1  high in ARMED, ENTRY_DELAY and ALARM.
REQ-012 siren  output  1  high only in ALARM.
REQ-013 lockout  output  1  high only in LOCKOUT.
REQ-014 fail_cnt  output  4  current consecutive-error count.
REQ-015 state_dbg  output  3  encoded state: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4, LOCKOUT=5.

Function
REQ-016 key_pulse and sensor SHALL each pass through a 2-flop synchronizer before use.
REQ-017 A key event SHALL be a 0->1 transition at the key_pulse synchronizer output; key_status SHALL be sampled in that same cycle (checker output is stable by then).
REQ-018 A key event SHALL be decoded as KOK (status 0) or KERR (status 2); status 3 and reserved status 1 SHALL be ignored.
REQ-019 State register SHALL update on the 3rd rising clk edge after key_pulse is first sampled high (2 sync stages + 1 decision cycle).
REQ-020 Entering a timed state SHALL load a 32-bit down-counter with its *_CYC-1; counter decrements every cycle; expiry = counter 0 in that state; each timed state lasts exactly *_CYC cycles absent other events.
REQ-021 DISARMED: KOK -> EXIT_DELAY; KERR -> fail_cnt+1, and if the new value equals MAX_FAILS -> LOCKOUT.
REQ-022 EXIT_DELAY: KOK -> DISARMED; expiry -> ARMED; KERR -> fail_cnt+1 with no escalation (saturates at MAX_FAILS); sensor ignored.
REQ-023 ARMED: KOK -> DISARMED; synchronized sensor high -> ENTRY_DELAY; KERR -> fail_cnt+1, reaching MAX_FAILS -> ALARM.
REQ-024 ENTRY_DELAY: KOK -> DISARMED; expiry -> ALARM; KERR -> fail_cnt+1, reaching MAX_FAILS -> ALARM immediately.
REQ-025 ALARM: KOK -> DISARMED; expiry -> ARMED (siren off, re-armed); KERR -> fail_cnt+1, saturating at MAX_FAILS; sensor ignored.
REQ-026 LOCKOUT: all key events ignored; expiry -> DISARMED.
REQ-027 Any KOK SHALL clear fail_cnt to 0 in the same cycle as its transition; entering LOCKOUT, ALARM or DISARMED-from-LOCKOUT SHALL clear fail_cnt to 0.
REQ-028 Priority within one cycle SHALL be: KOK > KERR escalation > timer expiry > sensor.
REQ-029 A key event coinciding with expiry SHALL win; counter value is then irrelevant as the new state reloads it.
REQ-030 Outputs SHALL be registered, decoded from the state register, free of glitches.

Reset
REQ-031 reset high at a clk edge SHALL force DISARMED, fail_cnt=0, counter=0, synchronizers and edge detector cleared, armed=siren=lockout=0, state_dbg=0.
REQ-032 reset SHALL take precedence over every event, including mid-delay and mid-ALARM; no key event SHALL be detected from a key_pulse already high at reset release until it falls and rises again.

Verification (EXIT_CYC=10, ENTRY_CYC=8, SIREN_CYC=20, LOCK_CYC=15, MAX_FAILS=3)
REQ-033 Reset, KOK pulse -> state_dbg 1 three edges later, 2 exactly 10 cycles after that, armed=1.
REQ-034 ARMED, sensor high 1 cycle -> state 3 after sync latency; no key for 8 cycles -> state 4, siren=1 for 20 cycles, then state 2, siren=0.
REQ-035 DISARMED, three KERR pulses -> fail_cnt 1,2, then state 5, lockout=1, fail_cnt=0; KOK during lockout ignored; after 15 cycles state 0.
REQ-036 ENTRY_DELAY, KOK whose event lands on the expiry cycle -> state 0, siren never asserts.
REQ-037 ARMED, KOK and sensor rise in same detected cycle -> state 0 (KOK wins); two KERR then KOK -> fail_cnt back to 0.
REQ-038 ALARM mid-siren, reset asserted 1 cycle -> all outputs 0, state 0 on the next edge; key_pulse held high across reset produces no event.
